// File: rtl/uart_tx_fc.sv
// uart_tx_fc: buffered 8N1 UART transmitter with CTS flow control.
// Ports: i_clk, i_rst, i_tx_valid/o_tx_ready/i_tx_data (push), o_tx, i_cts_n, o_busy, o_fifo_count.
module uart_tx_fc #(
  parameter int BaudRate             = 9600,
  parameter int SystemClockFrequency = 156250000,
  parameter int FifoDepth            = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_tx_valid,
  output logic                         o_tx_ready,
  input  logic [7:0]                   i_tx_data,
  output logic                         o_tx,
  input  logic                         i_cts_n,
  output logic                         o_busy,
  output logic [$clog2(FifoDepth):0]   o_fifo_count
);

  localparam int ClksPerBit = SystemClockFrequency / BaudRate;
  localparam int AW = $clog2(FifoDepth);
  localparam int CW = $clog2(ClksPerBit);
  localparam logic [CW-1:0] BitLast = CW'(ClksPerBit - 1);
  localparam logic [AW:0] Full = (AW+1)'(FifoDepth);

  if (ClksPerBit < 2) begin : g_bad_cpb
    $error("uart_tx_fc: ClksPerBit must be at least 2");
  end
  if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fc: FifoDepth must be a power of 2 and >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  logic          cts_meta;
  logic          cts_s;
  logic [7:0]    mem [FifoDepth];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;
  state_t        state;
  state_t        state_d;
  logic [CW-1:0] bit_cnt;
  logic [CW-1:0] bit_cnt_d;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_idx_d;
  logic [7:0]    tx_byte;
  logic [7:0]    tx_byte_d;
  logic          tx_d;
  logic          bit_end;
  logic          can_start;

  assign o_tx_ready   = count != Full;
  assign push         = i_tx_valid && o_tx_ready;
  assign o_fifo_count = count;
  assign o_busy       = state != S_IDLE;
  assign bit_end      = bit_cnt == BitLast;
  // CTS only gates the start of a frame, never an ongoing one.
  assign can_start    = (count != '0) && !cts_s;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cts_meta <= 1'b1;
      cts_s    <= 1'b1;
    end else begin
      cts_meta <= i_cts_n;
      cts_s    <= cts_meta;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_tx_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      tx_byte <= '0;
      o_tx    <= 1'b1;
    end else begin
      state   <= state_d;
      bit_cnt <= bit_cnt_d;
      bit_idx <= bit_idx_d;
      tx_byte <= tx_byte_d;
      o_tx    <= tx_d;
    end
  end

  always_comb begin
    state_d   = state;
    bit_cnt_d = '0;
    bit_idx_d = bit_idx;
    tx_byte_d = tx_byte;
    tx_d      = o_tx;
    pop       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (can_start) begin
          pop       = 1'b1;
          tx_byte_d = mem[rd_ptr];
          tx_d      = 1'b0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
          tx_d      = tx_byte[0];
        end else begin
          bit_cnt_d = bit_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx + 3'd1;
            tx_d      = tx_byte[bit_idx + 3'd1];
          end
        end else begin
          bit_cnt_d = bit_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          // Chain straight into the next start bit: no idle gap.
          if (can_start) begin
            pop       = 1'b1;
            tx_byte_d = mem[rd_ptr];
            tx_d      = 1'b0;
            state_d   = S_START;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fc.sv
// tb_uart_tx_fc: directed bench for uart_tx_fc at ClksPerBit=8, FifoDepth=16.
// Samples 1 time unit after each rising edge; drives inputs at that point.
module tb_uart_tx_fc;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [7:0] data;
  logic       cts_n;
  logic       tx;
  logic       ready;
  logic       busy;
  logic [4:0] count;
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;

  uart_tx_fc #(
    .BaudRate(10),
    .SystemClockFrequency(80),
    .FifoDepth(16)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_tx_valid(valid),
    .o_tx_ready(ready),
    .i_tx_data(data),
    .o_tx(tx),
    .i_cts_n(cts_n),
    .o_busy(busy),
    .o_fifo_count(count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    data  = b;
    valid = 1'b1;
    tick();
    valid = 1'b0;
  endtask

  // Waits (bounded) for a start bit, then samples each bit mid-way.
  task automatic rx_frame(input int tmo, output logic [7:0] d,
                          output int t0, output bit ok,
                          output logic stopb);
    int n;
    ok = 1'b0;
    d = '0;
    t0 = 0;
    stopb = 1'b0;
    n = 0;
    while (tx !== 1'b0 && n < tmo) begin
      tick();
      n++;
    end
    if (tx === 1'b0) begin
      t0 = cyc;
      repeat (4) tick();
      for (int i = 0; i < 8; i++) begin
        repeat (8) tick();
        d[i] = tx;
      end
      repeat (8) tick();
      stopb = tx;
      ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    total++;
    if (tx !== 1'b1) begin bad++; $display("FAIL rst_tx got=%b want=1", tx); end
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", ready); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++;
    if (count !== 5'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", count); end
    rst = 1'b0;
    cts_n = 1'b0;
    repeat (3) tick();
    total++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL post_rst_idle got tx=%b busy=%b want tx=1 busy=0", tx, busy);
    end
  endtask

  task automatic test_single_byte();
    logic [9:0] frame;
    logic       e;
    frame = {1'b1, 8'hA5, 1'b0};
    push(8'hA5);
    total++;
    if (count !== 5'd1) begin bad++; $display("FAIL sb_count1 got=%0d want=1", count); end
    total++;
    if (tx !== 1'b1) begin bad++; $display("FAIL sb_tx_pre got=%b want=1", tx); end
    tick();
    total++;
    if (count !== 5'd0) begin bad++; $display("FAIL sb_count0 got=%0d want=0", count); end
    for (int i = 0; i < 80; i++) begin
      e = frame[i/8];
      total++;
      if (tx !== e) begin bad++; $display("FAIL sb_tx cyc%0d got=%b want=%b", i, tx, e); end
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL sb_busy cyc%0d got=%b want=1", i, busy); end
      tick();
    end
    total++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      bad++;
      $display("FAIL sb_end got busy=%b tx=%b want busy=0 tx=1", busy, tx);
    end
  endtask

  task automatic test_fill_release();
    logic [7:0] d;
    int         t;
    int         first;
    int         prev;
    int         c0;
    bit         ok;
    logic       sb;
    bit         err;
    cts_n = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 16; i++) begin
      total++;
      if (ready !== 1'b1) begin bad++; $display("FAIL fill_ready%0d got=%b want=1", i, ready); end
      push(8'(i));
    end
    total++;
    if (ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b want=0", ready); end
    total++;
    if (count !== 5'd16) begin bad++; $display("FAIL full_count got=%0d want=16", count); end
    data = 8'h10;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    total++;
    if (count !== 5'd16) begin bad++; $display("FAIL drop_count got=%0d want=16", count); end
    err = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (tx !== 1'b1 || busy !== 1'b0) err = 1'b1;
      tick();
    end
    total++;
    if (err) begin bad++; $display("FAIL held_idle got=active want=idle"); end
    c0 = cyc;
    cts_n = 1'b0;
    first = 0;
    prev = 0;
    for (int k = 0; k < 16; k++) begin
      rx_frame(200, d, t, ok, sb);
      total++;
      if (!ok) begin bad++; $display("FAIL rel_timeout%0d got=none want=frame", k); end
      total++;
      if (d !== 8'(k)) begin bad++; $display("FAIL rel_data%0d got=%h want=%h", k, d, 8'(k)); end
      total++;
      if (sb !== 1'b1) begin bad++; $display("FAIL rel_stop%0d got=%b want=1", k, sb); end
      if (k == 0) begin
        first = t;
        total++;
        if (t !== c0 + 3) begin bad++; $display("FAIL rel_latency got=%0d want=%0d", t - c0, 3); end
      end else begin
        total++;
        if (t - prev !== 80) begin bad++; $display("FAIL rel_gap%0d got=%0d want=80", k, t - prev); end
      end
      prev = t;
    end
    total++;
    if (prev - first + 80 !== 1280) begin
      bad++;
      $display("FAIL rel_total got=%0d want=1280", prev - first + 80);
    end
    repeat (4) tick();
    total++;
    if (busy !== 1'b0 || count !== 5'd0) begin
      bad++;
      $display("FAIL rel_end got busy=%b count=%0d want busy=0 count=0", busy, count);
    end
    err = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (tx !== 1'b1) err = 1'b1;
      tick();
    end
    total++;
    if (err) begin bad++; $display("FAIL dropped_sent got=frame want=none"); end
  endtask

  task automatic test_cts_mid_frame();
    logic [7:0] d;
    logic       sb;
    logic       st;
    int         t;
    bit         ok;
    bit         err;
    push(8'h3C);
    push(8'h3D);
    total++;
    if (tx !== 1'b0 || count !== 5'd1) begin
      bad++;
      $display("FAIL cts_begin got tx=%b count=%0d want tx=0 count=1", tx, count);
    end
    repeat (4) tick();
    st = tx;
    for (int i = 0; i < 8; i++) begin
      repeat (8) tick();
      d[i] = tx;
      if (i == 3) cts_n = 1'b1;
    end
    repeat (8) tick();
    sb = tx;
    total++;
    if (d !== 8'h3C || st !== 1'b0 || sb !== 1'b1) begin
      bad++;
      $display("FAIL cts_frame got=%h/%b/%b want=3c/0/1", d, st, sb);
    end
    repeat (4) tick();
    total++;
    if (busy !== 1'b0 || count !== 5'd1) begin
      bad++;
      $display("FAIL cts_hold got busy=%b count=%0d want busy=0 count=1", busy, count);
    end
    err = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (tx !== 1'b1 || count !== 5'd1) err = 1'b1;
      tick();
    end
    total++;
    if (err) begin bad++; $display("FAIL cts_withheld got=active want=idle"); end
    cts_n = 1'b0;
    tick();
    tick();
    total++;
    if (tx !== 1'b1) begin bad++; $display("FAIL cts_early got=%b want=1", tx); end
    tick();
    total++;
    if (tx !== 1'b0) begin bad++; $display("FAIL cts_resume got=%b want=0", tx); end
    rx_frame(10, d, t, ok, sb);
    total++;
    if (!ok || d !== 8'h3D || sb !== 1'b1) begin
      bad++;
      $display("FAIL cts_next got=%h/%b want=3d/1", d, sb);
    end
    repeat (4) tick();
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    logic       sb;
    int         t;
    int         c;
    bit         ok;
    bit         err;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    repeat (20) tick();
    total++;
    if (busy !== 1'b1 || count !== 5'd3) begin
      bad++;
      $display("FAIL rmf_pre got busy=%b count=%0d want busy=1 count=3", busy, count);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (tx !== 1'b1) begin bad++; $display("FAIL rmf_tx got=%b want=1", tx); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL rmf_busy got=%b want=0", busy); end
    total++;
    if (count !== 5'd0) begin bad++; $display("FAIL rmf_count got=%0d want=0", count); end
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL rmf_ready got=%b want=1", ready); end
    err = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (tx !== 1'b1 || busy !== 1'b0) err = 1'b1;
      tick();
    end
    total++;
    if (err) begin bad++; $display("FAIL rmf_quiet got=active want=idle"); end
    push(8'h81);
    c = cyc;
    rx_frame(20, d, t, ok, sb);
    total++;
    if (!ok || t !== c + 1) begin bad++; $display("FAIL rmf_start got=%0d want=%0d", t, c + 1); end
    total++;
    if (d !== 8'h81 || sb !== 1'b1) begin
      bad++;
      $display("FAIL rmf_data got=%h/%b want=81/1", d, sb);
    end
    repeat (4) tick();
  endtask

  task automatic test_simul_push_pop();
    logic [7:0] exp_b [20];
    logic [7:0] rx_b [20];
    int         pn;
    int         pos;
    int         k;
    int         bi;
    bit         ferr;
    for (int i = 0; i < 20; i++) begin
      exp_b[i] = 8'(i * 37 + 5);
      rx_b[i] = '0;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    ferr = 1'b0;
    push(exp_b[0]);
    push(exp_b[1]);
    total++;
    if (tx !== 1'b0) begin bad++; $display("FAIL spp_start got=%b want=0", tx); end
    push(exp_b[2]);
    total++;
    if (count !== 5'd2) begin bad++; $display("FAIL spp_count_init got=%0d want=2", count); end
    pn = 3;
    for (int t = 1; t < 1600; t++) begin
      pos = t % 80;
      k = t / 80;
      if (pos == 0 && valid) begin
        valid = 1'b0;
        total++;
        if (count !== 5'd2) begin bad++; $display("FAIL spp_count t%0d got=%0d want=2", t, count); end
      end
      if (pos % 8 == 4) begin
        bi = pos / 8;
        if (bi == 0) begin
          if (tx !== 1'b0) ferr = 1'b1;
        end else if (bi == 9) begin
          if (tx !== 1'b1) ferr = 1'b1;
        end else begin
          rx_b[k][bi-1] = tx;
        end
      end
      if (pos == 79 && pn < 20) begin
        data = exp_b[pn];
        valid = 1'b1;
        pn++;
      end
      tick();
    end
    total++;
    if (ferr) begin bad++; $display("FAIL spp_framing got=bad want=start0/stop1"); end
    total++;
    if (busy !== 1'b0 || count !== 5'd0) begin
      bad++;
      $display("FAIL spp_end got busy=%b count=%0d want busy=0 count=0", busy, count);
    end
    for (int i = 0; i < 20; i++) begin
      total++;
      if (rx_b[i] !== exp_b[i]) begin
        bad++;
        $display("FAIL spp_byte%0d got=%h want=%h", i, rx_b[i], exp_b[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    valid = 1'b0;
    data = '0;
    cts_n = 1'b1;
    test_reset();
    test_single_byte();
    test_fill_release();
    test_cts_mid_frame();
    test_reset_mid_frame();
    test_simul_push_pop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
